// File: rtl/code_match_arbiter.sv
// Round-robin arbiter sharing one code comparator between NUM_REQ requesters.
// Each result is held on a registered valid/ready port, and accepted matches are counted.
module code_match_arbiter #(
    parameter int                NUM_REQ    = 4,
    parameter int                CODE_W     = 6,
    parameter logic [CODE_W-1:0] MATCH_CODE = 6'd3,
    parameter logic [1:0]        TAG        = 2'd1,
    parameter int                CNT_W      = 16,
    localparam int               IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*CODE_W-1:0] req_code,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [2:0]                rsp_result,
    output logic [CNT_W-1:0]          match_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      ptr_d;
    logic                rsp_valid_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [2:0]          rsp_result_q;
    logic [CNT_W-1:0]    match_cnt_q;
    logic [CNT_W-1:0]    match_cnt_d;

    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [CODE_W-1:0]   grant_code;
    int                  idx;

    // Scan from the farthest offset back to ptr so the nearest valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        grant_code  = req_code[int'(grant_idx)*CODE_W +: CODE_W];
        ptr_d       = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        match_cnt_d = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : match_cnt_q + CNT_W'(1);
        req_ready   = '0;
        if (!rst && state_q == IDLE && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            match_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        rsp_id_q     <= grant_idx;
                        rsp_result_q <= {TAG, grant_code == MATCH_CODE};
                        ptr_q        <= ptr_d;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    // The grant bubble after a handshake keeps spacing at two cycles.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        if (rsp_result_q[0]) begin
                            match_cnt_q <= match_cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_code_match_arbiter.sv
// Directed bench for code_match_arbiter; a second instance with a 2-bit counter
// shares the stimulus to exercise match counter saturation.
module tb_code_match_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_code;
    logic        rsp_ready;

    wire  [3:0]  req_ready;
    wire         rsp_valid;
    wire  [1:0]  rsp_id;
    wire  [2:0]  rsp_result;
    wire  [15:0] match_cnt;

    wire  [3:0]  satReqReady;
    wire         satRspValid;
    wire  [1:0]  satRspId;
    wire  [2:0]  satRspResult;
    wire  [1:0]  satMatchCnt;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    code_match_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .match_cnt  (match_cnt)
    );

    code_match_arbiter #(.CNT_W(2)) dutSat (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .req_ready  (satReqReady),
        .rsp_valid  (satRspValid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (satRspId),
        .rsp_result (satRspResult),
        .match_cnt  (satMatchCnt)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic setCode(input int i, input logic [5:0] v);
        req_code[i*6 +: 6] = v;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_code = '0; rsp_ready = 1'b0;
        setCode(0, 6'd3);
        step();
        step();
        #1;
        checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset_ready got %b want 0000", req_ready); else passCount++;
        checkCount++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", rsp_valid); else passCount++;
        checkCount++; if (rsp_id !== 2'd0) $display("[TB] FAIL reset_id got %0d want 0", rsp_id); else passCount++;
        checkCount++; if (rsp_result !== 3'b000) $display("[TB] FAIL reset_result got %b want 000", rsp_result); else passCount++;
        checkCount++; if (match_cnt !== 16'd0) $display("[TB] FAIL reset_cnt got %0d want 0", match_cnt); else passCount++;
        req_valid = 4'b0000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 4'b0001; setCode(0, 6'd3); rsp_ready = 1'b1;
        #1;
        checkCount++; if (req_ready !== 4'b0001) $display("[TB] FAIL single_ready got %b want 0001", req_ready); else passCount++;
        step();
        req_valid = 4'b0000;
        #1;
        checkCount++; if (rsp_valid !== 1'b1) $display("[TB] FAIL single_valid got %b want 1", rsp_valid); else passCount++;
        checkCount++; if (rsp_id !== 2'd0) $display("[TB] FAIL single_id got %0d want 0", rsp_id); else passCount++;
        checkCount++; if (rsp_result !== 3'b011) $display("[TB] FAIL single_result got %b want 011", rsp_result); else passCount++;
        checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL single_busy_ready got %b want 0000", req_ready); else passCount++;
        step();
        #1;
        checkCount++; if (rsp_valid !== 1'b0) $display("[TB] FAIL single_done_valid got %b want 0", rsp_valid); else passCount++;
        checkCount++; if (match_cnt !== 16'd1) $display("[TB] FAIL single_cnt got %0d want 1", match_cnt); else passCount++;
    endtask

    task automatic test_nonmatch();
        req_valid = 4'b0100; setCode(2, 6'd2); rsp_ready = 1'b1;
        #1;
        checkCount++; if (req_ready !== 4'b0100) $display("[TB] FAIL nonmatch_ready got %b want 0100", req_ready); else passCount++;
        step();
        req_valid = 4'b0000;
        #1;
        checkCount++; if (rsp_id !== 2'd2) $display("[TB] FAIL nonmatch_id got %0d want 2", rsp_id); else passCount++;
        checkCount++; if (rsp_result !== 3'b010) $display("[TB] FAIL nonmatch_result got %b want 010", rsp_result); else passCount++;
        step();
        #1;
        checkCount++; if (match_cnt !== 16'd1) $display("[TB] FAIL nonmatch_cnt got %0d want 1", match_cnt); else passCount++;
    endtask

    task automatic test_round_robin();
        logic [1:0] expId[5]     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [2:0] expResult[5] = '{3'b011, 3'b010, 3'b011, 3'b010, 3'b011};
        logic [3:0] expReady;
        pulseReset();
        setCode(0, 6'd3); setCode(1, 6'd5); setCode(2, 6'd3); setCode(3, 6'd63);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            expReady = 4'b0001 << expId[t];
            #1;
            checkCount++; if (req_ready !== expReady) $display("[TB] FAIL rr_ready[%0d] got %b want %b", t, req_ready, expReady); else passCount++;
            step();
            #1;
            checkCount++; if (rsp_valid !== 1'b1 || rsp_id !== expId[t]) $display("[TB] FAIL rr_id[%0d] got v=%b id=%0d want v=1 id=%0d", t, rsp_valid, rsp_id, expId[t]); else passCount++;
            checkCount++; if (rsp_result !== expResult[t]) $display("[TB] FAIL rr_result[%0d] got %b want %b", t, rsp_result, expResult[t]); else passCount++;
            checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL rr_busy_ready[%0d] got %b want 0000", t, req_ready); else passCount++;
            step();
        end
        #1;
        checkCount++; if (match_cnt !== 16'd3) $display("[TB] FAIL rr_cnt got %0d want 3", match_cnt); else passCount++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        checkCount++; if (req_ready !== 4'b0010) $display("[TB] FAIL bp_ready got %b want 0010", req_ready); else passCount++;
        step();
        for (int c = 0; c < 5; c++) begin
            #1;
            checkCount++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 3'b010) $display("[TB] FAIL bp_hold[%0d] got v=%b id=%0d res=%b want v=1 id=1 res=010", c, rsp_valid, rsp_id, rsp_result); else passCount++;
            checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_ready_hold[%0d] got %b want 0000", c, req_ready); else passCount++;
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp_handshake_ready got %b want 0000", req_ready); else passCount++;
        step();
        #1;
        checkCount++; if (rsp_valid !== 1'b0) $display("[TB] FAIL bp_release_valid got %b want 0", rsp_valid); else passCount++;
        checkCount++; if (req_ready !== 4'b0100) $display("[TB] FAIL bp_next_ready got %b want 0100", req_ready); else passCount++;
        checkCount++; if (match_cnt !== 16'd3) $display("[TB] FAIL bp_cnt got %0d want 3", match_cnt); else passCount++;
    endtask

    task automatic test_reset_midop();
        req_valid = 4'b0010;
        #1;
        checkCount++; if (req_ready !== 4'b0010) $display("[TB] FAIL mid_wrap_ready got %b want 0010", req_ready); else passCount++;
        step();
        rsp_ready = 1'b0;
        #1;
        checkCount++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) $display("[TB] FAIL mid_pending got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); else passCount++;
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        checkCount++; if (req_ready !== 4'b0000) $display("[TB] FAIL mid_rst_ready got %b want 0000", req_ready); else passCount++;
        step();
        #1;
        checkCount++; if (rsp_valid !== 1'b0) $display("[TB] FAIL mid_valid got %b want 0", rsp_valid); else passCount++;
        checkCount++; if (match_cnt !== 16'd0) $display("[TB] FAIL mid_cnt got %0d want 0", match_cnt); else passCount++;
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checkCount++; if (req_ready !== 4'b0001) $display("[TB] FAIL mid_next_ready got %b want 0001", req_ready); else passCount++;
        step();
        #1;
        checkCount++; if (rsp_id !== 2'd0) $display("[TB] FAIL mid_next_id got %0d want 0", rsp_id); else passCount++;
    endtask

    task automatic test_saturation();
        logic [1:0] expSat;
        req_valid = 4'b0000;
        pulseReset();
        setCode(0, 6'd3);
        rsp_ready = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            req_valid = 4'b0001;
            step();
            req_valid = 4'b0000;
            step();
            expSat = (t > 3) ? 2'd3 : 2'(t);
            #1;
            checkCount++; if (match_cnt !== 16'(t)) $display("[TB] FAIL sat_wide_cnt[%0d] got %0d want %0d", t, match_cnt, t); else passCount++;
            checkCount++; if (satMatchCnt !== expSat) $display("[TB] FAIL sat_cnt[%0d] got %0d want %0d", t, satMatchCnt, expSat); else passCount++;
        end
        step();
        #1;
        checkCount++; if (satMatchCnt !== 2'd3) $display("[TB] FAIL sat_hold got %0d want 3", satMatchCnt); else passCount++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_nonmatch();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        test_saturation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
